// File: rtl/control_sequencer.sv
// Three-state (FETCH/EXEC/HALT) instruction sequencer: fetches 16-bit words,
// decodes them into a packed datapath control word and handles LD/ST stalls and branches.
module control_sequencer (
   input  logic        clk,
   input  logic        reset,
   input  logic [15:0] instr_in,
   input  logic        instr_valid,
   output logic [7:0]  instr_addr,
   output logic        instr_req,
   input  logic        mem_ready,
   output logic        mem_rd,
   output logic        mem_wr,
   input  logic        V,
   input  logic        C,
   input  logic        N,
   input  logic        Z,
   output logic [15:0] control_word,
   output logic [7:0]  constant_in,
   output logic        halted,
   output logic        illegal
);

   localparam logic [1:0] ST_FETCH = 2'd0;
   localparam logic [1:0] ST_EXEC  = 2'd1;
   localparam logic [1:0] ST_HALT  = 2'd2;

   localparam logic [3:0] OP_NOP  = 4'b0000;
   localparam logic [3:0] OP_ALU0 = 4'b0001;
   localparam logic [3:0] OP_ALU1 = 4'b0010;
   localparam logic [3:0] OP_ADDI = 4'b0011;
   localparam logic [3:0] OP_LD   = 4'b0100;
   localparam logic [3:0] OP_ST   = 4'b0101;
   localparam logic [3:0] OP_BZ   = 4'b0110;
   localparam logic [3:0] OP_BN   = 4'b0111;
   localparam logic [3:0] OP_JMP  = 4'b1000;
   localparam logic [3:0] OP_HALT = 4'b1111;

   logic [1:0]  state_q, state_d;
   logic [7:0]  pc_q, pc_d;
   logic [15:0] ir_q, ir_d;

   logic [3:0]  op;
   logic [2:0]  fld_d, fld_a, fld_b, fld_f;
   logic [15:0] cw_c;
   logic [7:0]  const_c;
   logic        req_c, rd_c, wr_c, halted_c, illegal_c;

   // Overflow and carry play no part in sequencing.
   logic unused_flags;
   assign unused_flags = V | C;

   assign op    = ir_q[15:12];
   assign fld_d = ir_q[11:9];
   assign fld_a = ir_q[8:6];
   assign fld_b = ir_q[5:3];
   assign fld_f = ir_q[2:0];

   function automatic logic [7:0] branch_target(input logic [7:0] pc, input logic [15:0] ir);
      logic [5:0] off;
      off = {ir[11:9], ir[5:3]};
      return pc + {{2{off[5]}}, off};
   endfunction

   function automatic logic [15:0] pack_cw(input logic [2:0] da, input logic [2:0] aa,
                                           input logic [2:0] ba, input logic mb,
                                           input logic [3:0] fs, input logic md,
                                           input logic rw);
      return {da, aa, ba, mb, fs, md, rw};
   endfunction

   always_comb begin
      state_d   = state_q;
      pc_d      = pc_q;
      ir_d      = ir_q;
      cw_c      = 16'h0000;
      const_c   = 8'h00;
      req_c     = 1'b0;
      rd_c      = 1'b0;
      wr_c      = 1'b0;
      halted_c  = 1'b0;
      illegal_c = 1'b0;
      case (state_q)
         ST_FETCH: begin
            req_c = 1'b1;
            if (instr_valid) begin
               ir_d    = instr_in;
               pc_d    = pc_q + 8'd1;
               state_d = ST_EXEC;
            end
         end
         ST_EXEC: begin
            state_d = ST_FETCH;
            case (op)
               OP_NOP: ;
               OP_ALU0, OP_ALU1:
                  cw_c = pack_cw(fld_d, fld_a, fld_b, 1'b0, {op[1], fld_f}, 1'b0, 1'b1);
               OP_ADDI: begin
                  cw_c    = pack_cw(fld_d, fld_a, 3'd0, 1'b1, 4'b0010, 1'b0, 1'b1);
                  const_c = {2'b00, ir_q[5:0]};
               end
               OP_LD: begin
                  // Register write only on the completing cycle, so one write per load.
                  cw_c = pack_cw(fld_d, fld_a, 3'd0, 1'b0, 4'b0000, 1'b1, mem_ready);
                  rd_c = 1'b1;
                  if (!mem_ready) state_d = ST_EXEC;
               end
               OP_ST: begin
                  cw_c = pack_cw(3'd0, fld_a, fld_b, 1'b0, 4'b0000, 1'b0, 1'b0);
                  wr_c = 1'b1;
                  if (!mem_ready) state_d = ST_EXEC;
               end
               OP_BZ, OP_BN: begin
                  cw_c = pack_cw(3'd0, fld_a, 3'd0, 1'b0, 4'b0000, 1'b0, 1'b0);
                  if ((op == OP_BZ) ? Z : N) pc_d = branch_target(pc_q, ir_q);
               end
               OP_JMP:  pc_d = ir_q[7:0];
               OP_HALT: state_d = ST_HALT;
               default: illegal_c = 1'b1;
            endcase
         end
         ST_HALT: halted_c = 1'b1;
         default: state_d = ST_FETCH;
      endcase
   end

   // Controls are held low while reset is asserted so an abandoned LD never writes.
   assign instr_addr   = pc_q;
   assign instr_req    = req_c & reset;
   assign control_word = cw_c & {16{reset}};
   assign constant_in  = const_c & {8{reset}};
   assign mem_rd       = rd_c & reset;
   assign mem_wr       = wr_c & reset;
   assign halted       = halted_c & reset;
   assign illegal      = illegal_c & reset;

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q <= ST_FETCH;
         pc_q    <= 8'h00;
         ir_q    <= 16'h0000;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         ir_q    <= ir_d;
      end
   end

endmodule

// File: tb/tb_control_sequencer.sv
// Scoreboard bench for control_sequencer: directed instruction stream, per-cycle expected outputs.
module tb_control_sequencer;

   logic        clk;
   logic        reset;
   logic [15:0] instr_in;
   logic        instr_valid;
   logic [7:0]  instr_addr;
   logic        instr_req;
   logic        mem_ready;
   logic        mem_rd;
   logic        mem_wr;
   logic        V, C, N, Z;
   logic [15:0] control_word;
   logic [7:0]  constant_in;
   logic        halted;
   logic        illegal;

   control_sequencer dut (
      .clk(clk), .reset(reset), .instr_in(instr_in), .instr_valid(instr_valid),
      .instr_addr(instr_addr), .instr_req(instr_req), .mem_ready(mem_ready),
      .mem_rd(mem_rd), .mem_wr(mem_wr), .V(V), .C(C), .N(N), .Z(Z),
      .control_word(control_word), .constant_in(constant_in),
      .halted(halted), .illegal(illegal)
   );

   typedef struct {
      int          cyc;
      string       name;
      logic [7:0]  addr;
      logic        req;
      logic [15:0] cw;
      logic [7:0]  k;
      logic        rd;
      logic        wr;
      logic        hlt;
      logic        ill;
   } exp_t;

   exp_t sb[$];
   int   cyc = 0;
   int   tests = 0;
   int   fails = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #100000;
      $display("FAIL timeout: simulation did not finish, required completion");
      $fatal(1, "timeout");
   end

   // Monitor: pops the expectation registered for the current cycle and compares.
   always @(negedge clk) begin
      exp_t e;
      while (sb.size() > 0 && sb[0].cyc < cyc) begin
         e = sb.pop_front();
         tests++;
         fails++;
         $display("FAIL %s: expectation for cycle %0d never checked (now %0d)", e.name, e.cyc, cyc);
      end
      if (sb.size() > 0 && sb[0].cyc == cyc) begin
         e = sb.pop_front();
         tests++;
         if (instr_addr !== e.addr || instr_req !== e.req || control_word !== e.cw ||
             constant_in !== e.k || mem_rd !== e.rd || mem_wr !== e.wr ||
             halted !== e.hlt || illegal !== e.ill) begin
            fails++;
            $display("FAIL %s: got addr=%h req=%b cw=%h k=%h rd=%b wr=%b hlt=%b ill=%b, want addr=%h req=%b cw=%h k=%h rd=%b wr=%b hlt=%b ill=%b",
                     e.name, instr_addr, instr_req, control_word, constant_in, mem_rd, mem_wr,
                     halted, illegal, e.addr, e.req, e.cw, e.k, e.rd, e.wr, e.hlt, e.ill);
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string nm, input logic [7:0] a, input logic rq, input logic [15:0] cw,
                      input logic [7:0] k, input logic rd, input logic wr, input logic h,
                      input logic il);
      exp_t e;
      e.cyc = cyc; e.name = nm; e.addr = a; e.req = rq; e.cw = cw; e.k = k;
      e.rd = rd; e.wr = wr; e.hlt = h; e.ill = il;
      sb.push_back(e);
   endtask

   task automatic fetch(input logic [15:0] w);
      instr_in    = w;
      instr_valid = 1'b1;
   endtask

   initial begin
      reset = 1'b0; instr_in = 16'h0000; instr_valid = 1'b0; mem_ready = 1'b0;
      V = 1'b0; C = 1'b0; N = 1'b0; Z = 1'b0;
      step();
      reset = 1'b1;

      fetch(16'h1298); chk("reset_fetch", 8'h00, 1, 16'h0000, 8'h00, 0, 0, 0, 0); step();
      instr_valid = 0; chk("alu_add", 8'h01, 0, 16'h2981, 8'h00, 0, 0, 0, 0); step();
      fetch(16'h342A); chk("fetch_addi", 8'h01, 1, 16'h0000, 8'h00, 0, 0, 0, 0); step();
      instr_valid = 0; chk("addi", 8'h02, 0, 16'h4049, 8'h2A, 0, 0, 0, 0); step();

      fetch(16'h4640); chk("fetch_ld", 8'h02, 1, 16'h0000, 8'h00, 0, 0, 0, 0); step();
      fetch(16'h1111); mem_ready = 0;
      for (int i = 0; i < 3; i++) begin
         chk("ld_wait", 8'h03, 0, 16'h6402, 8'h00, 1, 0, 0, 0); step();
      end
      instr_valid = 0; mem_ready = 1;
      chk("ld_done", 8'h03, 0, 16'h6403, 8'h00, 1, 0, 0, 0); step();

      fetch(16'h50A8); chk("ld_return", 8'h03, 1, 16'h0000, 8'h00, 0, 0, 0, 0); step();
      instr_valid = 0; chk("st", 8'h04, 0, 16'h0A80, 8'h00, 0, 1, 0, 0); step();
      mem_ready = 0;
      fetch(16'h9000); chk("st_return", 8'h04, 1, 16'h0000, 8'h00, 0, 0, 0, 0); step();
      instr_valid = 0; chk("illegal", 8'h05, 0, 16'h0000, 8'h00, 0, 0, 0, 1); step();

      fetch(16'h8010); chk("fetch_jmp", 8'h05, 1, 16'h0000, 8'h00, 0, 0, 0, 0); step();
      instr_valid = 0; chk("jmp", 8'h06, 0, 16'h0000, 8'h00, 0, 0, 0, 0); step();
      fetch(16'h6F30); chk("jmp_target", 8'h10, 1, 16'h0000, 8'h00, 0, 0, 0, 0); step();
      instr_valid = 0; Z = 1; chk("bz_exec", 8'h11, 0, 16'h1000, 8'h00, 0, 0, 0, 0); step();
      Z = 0; fetch(16'h6F30); chk("bz_taken", 8'h0F, 1, 16'h0000, 8'h00, 0, 0, 0, 0); step();
      instr_valid = 0; N = 1; chk("bz_n_exec", 8'h10, 0, 16'h1000, 8'h00, 0, 0, 0, 0); step();
      N = 0; fetch(16'h6F30); chk("bz_ignores_n", 8'h10, 1, 16'h0000, 8'h00, 0, 0, 0, 0); step();
      instr_valid = 0; chk("bz_nt_exec", 8'h11, 0, 16'h1000, 8'h00, 0, 0, 0, 0); step();
      fetch(16'h7F30); chk("bz_not_taken", 8'h11, 1, 16'h0000, 8'h00, 0, 0, 0, 0); step();
      instr_valid = 0; N = 1; V = 1; C = 1;
      chk("bn_exec", 8'h12, 0, 16'h1000, 8'h00, 0, 0, 0, 0); step();
      N = 0; V = 0; C = 0;
      fetch(16'h80FF); chk("bn_taken", 8'h10, 1, 16'h0000, 8'h00, 0, 0, 0, 0); step();
      instr_valid = 0; chk("jmp_ff", 8'h11, 0, 16'h0000, 8'h00, 0, 0, 0, 0); step();
      fetch(16'h0000); chk("at_ff", 8'hFF, 1, 16'h0000, 8'h00, 0, 0, 0, 0); step();
      instr_valid = 0; chk("nop_wrap", 8'h00, 0, 16'h0000, 8'h00, 0, 0, 0, 0); step();

      fetch(16'hF000); chk("wrap_fetch", 8'h00, 1, 16'h0000, 8'h00, 0, 0, 0, 0); step();
      instr_valid = 0; chk("halt_exec", 8'h01, 0, 16'h0000, 8'h00, 0, 0, 0, 0); step();
      fetch(16'h1298); mem_ready = 1;
      for (int i = 0; i < 3; i++) begin
         chk("halted", 8'h01, 0, 16'h0000, 8'h00, 0, 0, 1, 0); step();
      end
      instr_valid = 0; mem_ready = 0; reset = 0;
      chk("halt_in_reset", 8'h01, 0, 16'h0000, 8'h00, 0, 0, 0, 0); step();
      reset = 1;

      fetch(16'h4640); chk("halt_reset_exit", 8'h00, 1, 16'h0000, 8'h00, 0, 0, 0, 0); step();
      instr_valid = 0; chk("ld2_wait", 8'h01, 0, 16'h6402, 8'h00, 1, 0, 0, 0); step();
      reset = 0; mem_ready = 1;
      chk("ld_abort", 8'h01, 0, 16'h0000, 8'h00, 0, 0, 0, 0); step();
      reset = 1; mem_ready = 0;
      fetch(16'h2299); chk("after_abort", 8'h00, 1, 16'h0000, 8'h00, 0, 0, 0, 0); step();
      instr_valid = 0; chk("alu_sub", 8'h01, 0, 16'h29A5, 8'h00, 0, 0, 0, 0); step();
      chk("final_fetch", 8'h01, 1, 16'h0000, 8'h00, 0, 0, 0, 0);

      @(negedge clk);
      #1;
      tests++;
      if (instr_addr !== 8'h01) begin
         fails++;
         $display("FAIL final_addr: got %h, want 01", instr_addr);
      end
      tests++;
      if (instr_req !== 1'b1) begin
         fails++;
         $display("FAIL final_req: got %b, want 1", instr_req);
      end
      tests++;
      if (control_word !== 16'h0000) begin
         fails++;
         $display("FAIL final_cw: got %h, want 0000", control_word);
      end
      tests++;
      if (halted !== 1'b0) begin
         fails++;
         $display("FAIL final_halted: got %b, want 0", halted);
      end
      tests++;
      if (illegal !== 1'b0) begin
         fails++;
         $display("FAIL final_illegal: got %b, want 0", illegal);
      end
      while (sb.size() > 0) begin
         exp_t e;
         e = sb.pop_front();
         tests++;
         fails++;
         $display("FAIL %s: expectation left unchecked, required a check at cycle %0d", e.name, e.cyc);
      end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
